// File: rtl/aq_mmu_pkg.sv
// Shared MMU definitions: refill arbiter state encoding, default field widths
// and a clog2 helper for deriving index widths.
package aq_mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DRAIN = 2'b11
  } arb_st_e;

  localparam int unsigned DEF_VPN_W  = 28;
  localparam int unsigned DEF_ASID_W = 16;

  // Never returns less than 1 so a single-bit index always exists.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/aq_mmu_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above
// rr_ptr, wrapping from NUM_CH-1 back to 0.
module aq_mmu_rr_pick
  import aq_mmu_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              vld
);

  logic [CH_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(rr_ptr) + i) % NUM_CH);
      if (!vld && req[cand]) begin
        vld         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/aq_mmu_utlb_refill_arb.sv
// N-channel uTLB -> JTLB refill arbiter: round-robin pick, one outstanding
// refill, response routing to the owner, abort/flush handling in flight.
module aq_mmu_utlb_refill_arb
  import aq_mmu_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned VPN_W  = DEF_VPN_W,
  parameter int unsigned ASID_W = DEF_ASID_W,
  parameter int unsigned CH_W   = clog2(NUM_CH)
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst_b,
  input  logic [NUM_CH-1:0]        utlb_arb_req,
  input  logic [NUM_CH*VPN_W-1:0]  utlb_arb_vpn,
  input  logic [NUM_CH*ASID_W-1:0] utlb_arb_asid,
  input  logic [NUM_CH*2-1:0]      utlb_arb_mode,
  input  logic [NUM_CH-1:0]        utlb_arb_read,
  input  logic [NUM_CH-1:0]        utlb_arb_mach,
  input  logic [NUM_CH-1:0]        utlb_arb_cmplt,
  input  logic                     tlboper_xx_clr,
  input  logic                     jtlb_arb_ack,
  input  logic                     jtlb_arb_cmplt,
  input  logic                     jtlb_arb_pavld,
  input  logic                     jtlb_arb_pgflt,
  input  logic                     jtlb_arb_acc_err,
  output logic [NUM_CH-1:0]        arb_utlb_grant,
  output logic                     arb_jtlb_req,
  output logic [VPN_W-1:0]         arb_jtlb_vpn,
  output logic [ASID_W-1:0]        arb_jtlb_asid,
  output logic [1:0]               arb_jtlb_mode,
  output logic                     arb_jtlb_read,
  output logic                     arb_jtlb_mach,
  output logic [CH_W-1:0]          arb_jtlb_ch,
  output logic [NUM_CH-1:0]        jtlb_utlb_ref_cmplt,
  output logic [NUM_CH-1:0]        jtlb_utlb_ref_pavld,
  output logic [NUM_CH-1:0]        jtlb_utlb_pgflt,
  output logic [NUM_CH-1:0]        jtlb_utlb_acc_err,
  output logic [1:0]               arb_top_cur_st
);

  arb_st_e             state_q, state_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]     owner_q, owner_d;
  logic [VPN_W-1:0]    vpn_q, vpn_d;
  logic [ASID_W-1:0]   asid_q, asid_d;
  logic [1:0]          mode_q, mode_d;
  logic                read_q, read_d;
  logic                mach_q, mach_d;
  logic [NUM_CH-1:0]   rsp_cmplt_q, rsp_cmplt_d;
  logic [NUM_CH-1:0]   rsp_pavld_q, rsp_pavld_d;
  logic [NUM_CH-1:0]   rsp_pgflt_q, rsp_pgflt_d;
  logic [NUM_CH-1:0]   rsp_acc_err_q, rsp_acc_err_d;

  logic [NUM_CH-1:0]   pick_grant;
  logic [CH_W-1:0]     pick_idx;
  logic                pick_vld;
  logic                kill;
  logic [CH_W-1:0]     rr_next;

  aq_mmu_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req    (utlb_arb_req),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .vld    (pick_vld)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    vpn_d         = vpn_q;
    asid_d        = asid_q;
    mode_d        = mode_q;
    read_d        = read_q;
    mach_d        = mach_q;
    rsp_cmplt_d   = '0;
    rsp_pavld_d   = '0;
    rsp_pgflt_d   = '0;
    rsp_acc_err_d = '0;
    arb_utlb_grant = '0;

    // Only the owner's withdraw counts; other channels' aborts are ignored.
    kill = utlb_arb_cmplt[owner_q] | tlboper_xx_clr;
    if (32'(owner_q) == NUM_CH - 1) rr_next = '0;
    else                            rr_next = owner_q + CH_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          arb_utlb_grant = pick_grant;
          owner_d        = pick_idx;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pick_idx == CH_W'(i)) begin
              vpn_d  = utlb_arb_vpn[i*VPN_W +: VPN_W];
              asid_d = utlb_arb_asid[i*ASID_W +: ASID_W];
              mode_d = utlb_arb_mode[i*2 +: 2];
              read_d = utlb_arb_read[i];
              mach_d = utlb_arb_mach[i];
            end
          end
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // An accepted request must still be drained even if aborted.
        if (jtlb_arb_ack)  state_d = kill ? ST_DRAIN : ST_WAIT;
        else if (kill)     state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (jtlb_arb_cmplt) begin
          state_d  = ST_IDLE;
          rr_ptr_d = rr_next;
          if (!kill) begin
            rsp_cmplt_d[owner_q]   = 1'b1;
            rsp_pavld_d[owner_q]   = jtlb_arb_pavld;
            rsp_pgflt_d[owner_q]   = jtlb_arb_pgflt;
            rsp_acc_err_d[owner_q] = jtlb_arb_acc_err;
          end
        end else if (kill) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (jtlb_arb_cmplt) begin
          state_d  = ST_IDLE;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      vpn_q         <= '0;
      asid_q        <= '0;
      mode_q        <= '0;
      read_q        <= 1'b0;
      mach_q        <= 1'b0;
      rsp_cmplt_q   <= '0;
      rsp_pavld_q   <= '0;
      rsp_pgflt_q   <= '0;
      rsp_acc_err_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      vpn_q         <= vpn_d;
      asid_q        <= asid_d;
      mode_q        <= mode_d;
      read_q        <= read_d;
      mach_q        <= mach_d;
      rsp_cmplt_q   <= rsp_cmplt_d;
      rsp_pavld_q   <= rsp_pavld_d;
      rsp_pgflt_q   <= rsp_pgflt_d;
      rsp_acc_err_q <= rsp_acc_err_d;
    end
  end

  assign arb_jtlb_req        = (state_q == ST_REQ);
  assign arb_jtlb_vpn        = vpn_q;
  assign arb_jtlb_asid       = asid_q;
  assign arb_jtlb_mode       = mode_q;
  assign arb_jtlb_read       = read_q;
  assign arb_jtlb_mach       = mach_q;
  assign arb_jtlb_ch         = owner_q;
  assign jtlb_utlb_ref_cmplt = rsp_cmplt_q;
  assign jtlb_utlb_ref_pavld = rsp_pavld_q;
  assign jtlb_utlb_pgflt     = rsp_pgflt_q;
  assign jtlb_utlb_acc_err   = rsp_acc_err_q;
  assign arb_top_cur_st      = state_q;

endmodule

// File: tb/tb_aq_mmu_utlb_refill_arb.sv
// Directed bench for the 4-channel refill arbiter; grants and responses are
// checked against scoreboard queues filled as stimulus is driven.
module tb_aq_mmu_utlb_refill_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned VW = 28;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*VW-1:0] vpn;
  logic [N*AW-1:0] asid;
  logic [N*2-1:0]  mode;
  logic [N-1:0]    rd;
  logic [N-1:0]    mach;
  logic [N-1:0]    ucmplt;
  logic            clr, ack, jcmplt, pavld, pgflt, accerr;

  logic [N-1:0]    grant;
  logic            jreq;
  logic [VW-1:0]   jvpn;
  logic [AW-1:0]   jasid;
  logic [1:0]      jmode;
  logic            jread, jmach;
  logic [CW-1:0]   jch;
  logic [N-1:0]    r_cmplt, r_pavld, r_pgflt, r_acc;
  logic [1:0]      st;
  logic [4*N-1:0]  rsp_obs;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0]   gnt_q[$];
  logic [4*N-1:0] rsp_q[$];
  logic [N-1:0]   oh;

  aq_mmu_utlb_refill_arb #(
    .NUM_CH (N),
    .VPN_W  (VW),
    .ASID_W (AW)
  ) dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (rst_n),
    .utlb_arb_req        (req),
    .utlb_arb_vpn        (vpn),
    .utlb_arb_asid       (asid),
    .utlb_arb_mode       (mode),
    .utlb_arb_read       (rd),
    .utlb_arb_mach       (mach),
    .utlb_arb_cmplt      (ucmplt),
    .tlboper_xx_clr      (clr),
    .jtlb_arb_ack        (ack),
    .jtlb_arb_cmplt      (jcmplt),
    .jtlb_arb_pavld      (pavld),
    .jtlb_arb_pgflt      (pgflt),
    .jtlb_arb_acc_err    (accerr),
    .arb_utlb_grant      (grant),
    .arb_jtlb_req        (jreq),
    .arb_jtlb_vpn        (jvpn),
    .arb_jtlb_asid       (jasid),
    .arb_jtlb_mode       (jmode),
    .arb_jtlb_read       (jread),
    .arb_jtlb_mach       (jmach),
    .arb_jtlb_ch         (jch),
    .jtlb_utlb_ref_cmplt (r_cmplt),
    .jtlb_utlb_ref_pavld (r_pavld),
    .jtlb_utlb_pgflt     (r_pgflt),
    .jtlb_utlb_acc_err   (r_acc),
    .arb_top_cur_st      (st)
  );

  always #5 clk = ~clk;

  assign rsp_obs = {r_cmplt, r_pavld, r_pgflt, r_acc};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_pl(input int ch, input logic [VW-1:0] v, input logic [AW-1:0] a,
                        input logic [1:0] m, input logic r, input logic mc);
    vpn[ch*VW +: VW]  = v;
    asid[ch*AW +: AW] = a;
    mode[ch*2 +: 2]   = m;
    rd[ch]            = r;
    mach[ch]          = mc;
  endtask

  // Scoreboard: every grant / response pulse must match the next expected entry.
  always @(negedge clk) begin
    if (grant != '0) begin
      if (gnt_q.size() == 0) chk("grant_unexpected", 64'(grant), 64'd0);
      else                   chk("grant", 64'(grant), 64'(gnt_q.pop_front()));
    end
    if (rsp_obs != '0) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_obs), 64'd0);
      else                   chk("rsp", 64'(rsp_obs), 64'(rsp_q.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; vpn = '0; asid = '0; mode = '0; rd = '0; mach = '0;
    ucmplt = '0; clr = 0; ack = 0; jcmplt = 0; pavld = 0; pgflt = 0; accerr = 0;
    cyc(); cyc();
    chk("rst_state", 64'(st), 64'd0);
    chk("rst_jreq", 64'(jreq), 64'd0);
    chk("rst_vpn", 64'(jvpn), 64'd0);
    chk("rst_ch", 64'(jch), 64'd0);
    chk("rst_rsp", 64'(rsp_obs), 64'd0);
    rst_n = 1'b1;

    // T1: req 1010 with rr_ptr 0 -> ch1, then ch3
    set_pl(1, 28'h1234567, 16'h55AA, 2'b11, 1'b1, 1'b0);
    set_pl(3, 28'hABCDEF0, 16'h0F0F, 2'b01, 1'b0, 1'b1);
    req = 4'b1010;
    gnt_q.push_back(4'b0010);
    settle();
    chk("t1_grant_now", 64'(grant), 64'h2);
    cyc(); req[1] = 1'b0; ack = 1'b1; settle();
    chk("t1_state_req", 64'(st), 64'd1);
    chk("t1_jreq", 64'(jreq), 64'd1);
    chk("t1_vpn", 64'(jvpn), 64'h1234567);
    chk("t1_ch", 64'(jch), 64'd1);
    chk("t1_asid", 64'(jasid), 64'h55AA);
    chk("t1_mode", 64'(jmode), 64'd3);
    chk("t1_read", 64'(jread), 64'd1);
    chk("t1_mach", 64'(jmach), 64'd0);
    cyc(); ack = 1'b0; settle();
    chk("t1_state_wait", 64'(st), 64'd2);
    chk("t1_jreq_low", 64'(jreq), 64'd0);
    chk("t1_vpn_hold", 64'(jvpn), 64'h1234567);
    cyc(); jcmplt = 1'b1; pavld = 1'b1;
    rsp_q.push_back({4'b0010, 4'b0010, 4'b0000, 4'b0000});
    gnt_q.push_back(4'b1000);
    cyc(); jcmplt = 1'b0; pavld = 1'b0; settle();
    chk("t1_pavld", 64'(r_pavld), 64'h2);
    chk("t1_next_grant", 64'(grant), 64'h8);
    cyc(); req[3] = 1'b0; ack = 1'b1; settle();
    chk("t1_ch3", 64'(jch), 64'd3);
    chk("t1_vpn3", 64'(jvpn), 64'hABCDEF0);
    chk("t1_mach3", 64'(jmach), 64'd1);
    chk("t1_mode3", 64'(jmode), 64'd1);
    cyc(); ack = 1'b0; jcmplt = 1'b1; accerr = 1'b1;
    rsp_q.push_back({4'b1000, 4'b0000, 4'b0000, 4'b1000});
    cyc(); jcmplt = 1'b0; accerr = 1'b0; settle();
    chk("t1_acc_err", 64'(r_acc), 64'h8);
    cyc(); settle();
    chk("t1_acc_err_one_cycle", 64'(r_acc), 64'd0);
    chk("t1_idle", 64'(st), 64'd0);

    // T2: all four held -> 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'(1 << (k % 4));
      gnt_q.push_back(oh);
      cyc(); ack = 1'b1; settle();
      chk("t2_owner", 64'(jch), 64'(k % 4));
      cyc(); ack = 1'b0; jcmplt = 1'b1; pavld = 1'b1;
      rsp_q.push_back({oh, oh, 4'b0000, 4'b0000});
      if (k == 4) req = '0;
      cyc(); jcmplt = 1'b0; pavld = 1'b0;
    end

    // T3: owner ch0 aborts in WAIT -> DRAIN, silent completion, rr_ptr = 1
    cyc(); req = 4'b0001; gnt_q.push_back(4'b0001);
    cyc(); req = '0; ack = 1'b1;
    cyc(); ack = 1'b0; ucmplt = 4'b0001; settle();
    chk("t3_wait", 64'(st), 64'd2);
    cyc(); ucmplt = '0; settle();
    chk("t3_drain", 64'(st), 64'd3);
    cyc(); jcmplt = 1'b1; pavld = 1'b1; settle();
    chk("t3_drain_hold", 64'(st), 64'd3);
    cyc(); jcmplt = 1'b0; pavld = 1'b0; settle();
    chk("t3_idle", 64'(st), 64'd0);
    chk("t3_no_rsp", 64'(r_cmplt), 64'd0);
    req = 4'b0011; gnt_q.push_back(4'b0010);

    // T4: non-owner abort ignored, then flush in REQ drops the request
    cyc(); req = '0; ucmplt = 4'b0001; settle();
    chk("t4_req_state", 64'(st), 64'd1);
    chk("t4_owner", 64'(jch), 64'd1);
    cyc(); ucmplt = '0; settle();
    chk("t4_nonowner_ignored", 64'(st), 64'd1);
    clr = 1'b1;
    cyc(); clr = 1'b0; settle();
    chk("t4_clr_idle", 64'(st), 64'd0);
    chk("t4_clr_jreq", 64'(jreq), 64'd0);

    // T5: page fault routed to ch1 for one cycle
    req = 4'b0011; gnt_q.push_back(4'b0010);
    cyc(); req = '0; ack = 1'b1;
    cyc(); ack = 1'b0; jcmplt = 1'b1; pgflt = 1'b1;
    rsp_q.push_back({4'b0010, 4'b0000, 4'b0010, 4'b0000});
    cyc(); jcmplt = 1'b0; pgflt = 1'b0; settle();
    chk("t5_pgflt", 64'(r_pgflt), 64'h2);
    chk("t5_cmplt", 64'(r_cmplt), 64'h2);
    cyc(); settle();
    chk("t5_pgflt_gone", 64'(r_pgflt), 64'd0);
    chk("t5_cmplt_gone", 64'(r_cmplt), 64'd0);

    // T6: abort coincident with ack -> DRAIN
    req = 4'b0100; gnt_q.push_back(4'b0100);
    cyc(); req = '0; ack = 1'b1; ucmplt = 4'b0100;
    cyc(); ack = 1'b0; ucmplt = '0; settle();
    chk("t6_drain", 64'(st), 64'd3);
    jcmplt = 1'b1; pavld = 1'b1;
    cyc(); jcmplt = 1'b0; pavld = 1'b0; settle();
    chk("t6_idle", 64'(st), 64'd0);

    // T7: flush coincident with completion -> response suppressed
    req = 4'b1000; gnt_q.push_back(4'b1000);
    cyc(); req = '0; ack = 1'b1;
    cyc(); ack = 1'b0; jcmplt = 1'b1; pavld = 1'b1; clr = 1'b1;
    cyc(); jcmplt = 1'b0; pavld = 1'b0; clr = 1'b0; settle();
    chk("t7_idle", 64'(st), 64'd0);
    chk("t7_no_pavld", 64'(r_pavld), 64'd0);

    // T8: reset during WAIT, late completion ignored
    set_pl(0, 28'h0FEDCBA, 16'h1357, 2'b10, 1'b1, 1'b1);
    req = 4'b0001; gnt_q.push_back(4'b0001);
    cyc(); req = '0; ack = 1'b1; settle();
    chk("t8_vpn0", 64'(jvpn), 64'h0FEDCBA);
    cyc(); ack = 1'b0; rst_n = 1'b0;
    cyc(); settle();
    chk("t8_rst_state", 64'(st), 64'd0);
    chk("t8_rst_jreq", 64'(jreq), 64'd0);
    chk("t8_rst_vpn", 64'(jvpn), 64'd0);
    chk("t8_rst_asid", 64'(jasid), 64'd0);
    chk("t8_rst_mach", 64'(jmach), 64'd0);
    rst_n = 1'b1; jcmplt = 1'b1; pavld = 1'b1;
    cyc(); jcmplt = 1'b0; pavld = 1'b0; settle();
    chk("t8_late_state", 64'(st), 64'd0);
    chk("t8_late_no_rsp", 64'(r_cmplt), 64'd0);
    cyc(); cyc();

    chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
